// File: rtl/exec_byte_serializer.sv
// Byte serializer: accepts one 40-bit execute result word and streams it out
// one byte per valid/ready transfer, optionally byte-reversed. Optional parity: SERIALIZER_PARITY_EN.
module exec_byte_serializer #(
    parameter int unsigned BYTES  = 5,
    parameter int unsigned BYTE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BYTES*BYTE_W-1:0] dataInSerializer,
    input  logic                    controlInLoad,
    output logic                    controlOutReady,
    input  logic                    controlInReorderEnable,
    output logic [BYTE_W-1:0]       dataOutByte,
    output logic                    controlOutByteValid,
    input  logic                    controlInByteReady,
    output logic                    controlOutLast,
    output logic                    controlOutParity
);

    localparam int unsigned WORD_W   = BYTES * BYTE_W;
    localparam logic [2:0]  LAST_IDX = 3'(BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state, stateNext;
    logic [2:0]          cnt, cntNext;
    logic [WORD_W-1:0]   wordReg, wordNext;
    logic                reorderReg, reorderNext;
    logic [BYTE_W-1:0]   byteNext;
    logic                validNext, readyNext, lastNext;

    // Transfer position idx maps to byte idx (natural) or byte LAST_IDX-idx (reversed).
    function automatic logic [BYTE_W-1:0] selectByte(
        input logic [WORD_W-1:0] w,
        input logic              rev,
        input logic [2:0]        idx
    );
        logic [2:0] pos;
        pos = rev ? (LAST_IDX - idx) : idx;
        case (pos)
            3'd0:    selectByte = w[0*BYTE_W +: BYTE_W];
            3'd1:    selectByte = w[1*BYTE_W +: BYTE_W];
            3'd2:    selectByte = w[2*BYTE_W +: BYTE_W];
            3'd3:    selectByte = w[3*BYTE_W +: BYTE_W];
            3'd4:    selectByte = w[4*BYTE_W +: BYTE_W];
            default: selectByte = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            wordReg             <= '0;
            reorderReg          <= 1'b0;
            dataOutByte         <= '0;
            controlOutByteValid <= 1'b0;
            controlOutReady     <= 1'b1;
            controlOutLast      <= 1'b0;
        end else begin
            state               <= stateNext;
            cnt                 <= cntNext;
            wordReg             <= wordNext;
            reorderReg          <= reorderNext;
            dataOutByte         <= byteNext;
            controlOutByteValid <= validNext;
            controlOutReady     <= readyNext;
            controlOutLast      <= lastNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (controlInLoad) stateNext = SEND;
            SEND: begin
                if (cnt > LAST_IDX)
                    stateNext = IDLE;
                else if (controlInByteReady && cnt == LAST_IDX)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath, so every output comes from a flop.
    always_comb begin
        cntNext     = cnt;
        wordNext    = wordReg;
        reorderNext = reorderReg;
        byteNext    = dataOutByte;
        validNext   = controlOutByteValid;
        readyNext   = controlOutReady;
        lastNext    = controlOutLast;
        case (state)
            IDLE: begin
                readyNext = 1'b1;
                validNext = 1'b0;
                lastNext  = 1'b0;
                byteNext  = '0;
                if (controlInLoad) begin
                    wordNext    = dataInSerializer;
                    reorderNext = controlInReorderEnable;
                    cntNext     = '0;
                    byteNext    = selectByte(dataInSerializer, controlInReorderEnable, 3'd0);
                    validNext   = 1'b1;
                    readyNext   = 1'b0;
                end
            end
            SEND: begin
                if (cnt > LAST_IDX || (controlInByteReady && cnt == LAST_IDX)) begin
                    cntNext   = '0;
                    byteNext  = '0;
                    validNext = 1'b0;
                    readyNext = 1'b1;
                    lastNext  = 1'b0;
                end else if (controlInByteReady) begin
                    cntNext  = cnt + 3'd1;
                    byteNext = selectByte(wordReg, reorderReg, cnt + 3'd1);
                    lastNext = ((cnt + 3'd1) == LAST_IDX);
                end
            end
            default: begin
                cntNext   = '0;
                byteNext  = '0;
                validNext = 1'b0;
                readyNext = 1'b1;
                lastNext  = 1'b0;
            end
        endcase
    end

`ifdef SERIALIZER_PARITY_EN
    logic parityReg;
    always_ff @(posedge clk) begin
        if (!rst_n) parityReg <= 1'b0;
        else        parityReg <= ^byteNext;
    end
    assign controlOutParity = parityReg;
`else
    assign controlOutParity = 1'b0;
`endif

endmodule

// File: tb/tb_exec_byte_serializer.sv
// Scoreboard bench for exec_byte_serializer: driver queues expected bytes per
// accepted word, a negedge monitor pops and compares on each byte transfer.
module tb_exec_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] dataIn;
    logic        load;
    logic        dutReady;
    logic        reorder;
    logic [7:0]  dutByte;
    logic        dutValid;
    logic        byteReady;
    logic        dutLast;
    logic        dutParity;

    always #5 clk = ~clk;

    exec_byte_serializer #(.BYTES(5), .BYTE_W(8)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .dataInSerializer       (dataIn),
        .controlInLoad          (load),
        .controlOutReady        (dutReady),
        .controlInReorderEnable (reorder),
        .dataOutByte            (dutByte),
        .controlOutByteValid    (dutValid),
        .controlInByteReady     (byteReady),
        .controlOutLast         (dutLast),
        .controlOutParity       (dutParity)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic       par;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   randMode = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic expParity(input logic [7:0] b);
`ifdef SERIALIZER_PARITY_EN
        return ^b;
`else
        return 1'b0;
`endif
    endfunction

    // Reference order: natural = byte 0..4, reversed = byte 4..0.
    task automatic pushWord(input logic [39:0] w, input logic rev);
        exp_t e;
        int   idx;
        for (int k = 0; k < 5; k++) begin
            idx    = rev ? 4 - k : k;
            e.b    = w[8*idx +: 8];
            e.last = (k == 4);
            e.par  = expParity(e.b);
            expQ.push_back(e);
        end
    endtask

    // Monitor: compare on every transfer, check stability while stalled.
    logic       holdValid = 1'b0;
    logic [9:0] holdVal;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_xor_valid", {39'b0, dutReady ^ dutValid}, 40'd1);
            if (dutValid) begin
                if (holdValid)
                    check("hold_stable", {30'b0, dutByte, dutLast, dutParity}, {30'b0, holdVal});
                if (byteReady) begin
                    holdValid = 1'b0;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_byte actual=%0h required=none", dutByte);
                    end else begin
                        exp_t e;
                        e = expQ.pop_front();
                        check("byte", {32'b0, dutByte}, {32'b0, e.b});
                        check("last", {39'b0, dutLast}, {39'b0, e.last});
                        check("parity", {39'b0, dutParity}, {39'b0, e.par});
                    end
                end else begin
                    holdValid = 1'b1;
                    holdVal   = {dutByte, dutLast, dutParity};
                end
            end else begin
                holdValid = 1'b0;
            end
        end else begin
            holdValid = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        load = 1'b0;
        if (randMode) begin
            byteReady = ($urandom % 3) != 0;
            // Loads while busy must be ignored; they are never scoreboarded.
            if (!dutReady && ($urandom % 4) == 0) begin
                load   = 1'b1;
                dataIn = {8'($urandom), 32'($urandom)};
            end
        end
    endtask

    task automatic waitReady;
        int n = 0;
        while (!dutReady && n < 200) begin
            tick();
            n++;
        end
        if (!dutReady) check("ready_timeout", {39'b0, dutReady}, 40'd1);
    endtask

    task automatic sendWord(input logic [39:0] w, input logic rev);
        waitReady();
        load    = 1'b1;
        dataIn  = w;
        reorder = rev;
        pushWord(w, rev);
        tick();
        dataIn  = {8'($urandom), 32'($urandom)};
        reorder = 1'($urandom);
    endtask

    task automatic drain;
        int n = 0;
        while ((expQ.size() != 0 || !dutReady) && n < 500) begin
            tick();
            n++;
        end
        check("drain_queue", 40'(expQ.size()), 40'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_ready"},  {39'b0, dutReady},  40'd1);
        check({tag, "_valid"},  {39'b0, dutValid},  40'd0);
        check({tag, "_byte"},   {32'b0, dutByte},   40'd0);
        check({tag, "_last"},   {39'b0, dutLast},   40'd0);
        check({tag, "_parity"}, {39'b0, dutParity}, 40'd0);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; dataIn = '0; reorder = 1'b0; byteReady = 1'b0;
        tick(); tick();
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        byteReady = 1'b1;
        tick();

        // Latency and throughput, natural then reversed order.
        for (int r = 0; r < 2; r++) begin
            sendWord(40'h1122334455, 1'(r));
            for (int k = 0; k < 5; k++) begin
                check("busy_valid", {39'b0, dutValid}, 40'd1);
                check("busy_ready", {39'b0, dutReady}, 40'd0);
                tick();
            end
            check("bubble_ready", {39'b0, dutReady}, 40'd1);
            check("bubble_valid", {39'b0, dutValid}, 40'd0);
        end

        // Three-cycle stall on byte 33.
        sendWord(40'h1122334455, 1'b0);
        tick(); tick();
        check("stall_byte", {32'b0, dutByte}, 40'h33);
        byteReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", {32'b0, dutByte}, 40'h33);
            check("stall_valid", {39'b0, dutValid}, 40'd1);
        end
        byteReady = 1'b1;
        tick(); tick();
        check("stall_last", {39'b0, dutLast}, 40'd1);
        tick();
        check("stall_done", {39'b0, dutReady}, 40'd1);

        // Load during SEND is ignored.
        sendWord(40'h1122334455, 1'b0);
        load = 1'b1; dataIn = 40'hAABBCCDDEE; reorder = 1'b1;
        tick();
        load = 1'b1; dataIn = 40'hAABBCCDDEE;
        tick();
        drain();
        sendWord(40'hAABBCCDDEE, 1'b1);
        drain();

        // Reset after two of five bytes.
        sendWord(40'h1122334455, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        byteReady = 1'b0;
        tick();
        checkIdleOutputs("midreset");
        expQ.delete();
        rst_n = 1'b1;
        byteReady = 1'b1;
        sendWord(40'h0102030405, 1'b0);
        drain();

        // Parity pattern 0,1,1,0,0 (when parity is built in).
        sendWord(40'h00FF070100, 1'b0);
        drain();

        // Randomized words with random backpressure and ignored loads.
        randMode = 1;
        for (int i = 0; i < 300; i++)
            sendWord({8'($urandom), 32'($urandom)}, 1'($urandom));
        drain();
        randMode = 0;
        byteReady = 1'b1;
        tick();

        check("final_queue", 40'(expQ.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
